// File: rtl/dm_pkg.sv
// Shared definitions for the multi-cycle data memory: access modes, FSM states,
// latency bounds.
package dm_pkg;

  localparam logic [2:0] MODE_W  = 3'd0;
  localparam logic [2:0] MODE_HU = 3'd1;
  localparam logic [2:0] MODE_HS = 3'd2;
  localparam logic [2:0] MODE_BU = 3'd3;
  localparam logic [2:0] MODE_BS = 3'd4;

  localparam int unsigned LatencyMin = 1;
  localparam int unsigned LatencyMax = 15;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDone
  } dm_state_e;

endpackage

// File: rtl/dm_lane_unit.sv
// Byte/halfword lane steering: merges store data into the old word, extends
// load data from the selected lane, and flags misaligned addresses.
module dm_lane_unit
  import dm_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] wd_i,
  input  logic [1:0]  a_lo_i,
  input  logic [2:0]  mode_i,
  output logic [31:0] merged_o,
  output logic [31:0] load_o,
  output logic        misalign_o
);

  logic [15:0] half;
  logic [7:0]  byte_v;

  always_comb begin
    half       = a_lo_i[1] ? old_word_i[31:16] : old_word_i[15:0];
    byte_v     = old_word_i[{a_lo_i, 3'b000} +: 8];
    merged_o   = old_word_i;
    load_o     = old_word_i;
    misalign_o = 1'b0;
    case (mode_i)
      MODE_W: begin
        merged_o   = wd_i;
        misalign_o = (a_lo_i != 2'b00);
      end
      MODE_HU, MODE_HS: begin
        merged_o[{a_lo_i[1], 4'b0000} +: 16] = wd_i[15:0];
        load_o     = {{16{(mode_i == MODE_HS) & half[15]}}, half};
        misalign_o = a_lo_i[0];
      end
      MODE_BU, MODE_BS: begin
        merged_o[{a_lo_i, 3'b000} +: 8] = wd_i[7:0];
        load_o = {{24{(mode_i == MODE_BS) & byte_v[7]}}, byte_v};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_mc.sv
// Multi-cycle data memory with req/ready handshake, configurable latency,
// sub-word access and misalignment detection.
module dm_mc
  import dm_pkg::*;
#(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned TRACE   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  mode,
  input  logic [31:0] PC,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  output logic        busy,
  output logic        ready,
  output logic [31:0] data,
  output logic        addr_err
);

  localparam int unsigned Depth   = 2 ** (ADDR_W - 2);
  localparam logic [3:0]  CntInit = 4'(LATENCY - 1);

  dm_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  mode_q, mode_d;
  logic [31:0] a_q, a_d, wd_q, wd_d, pc_q, pc_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
  logic [31:0] mem_q [Depth];

  logic [ADDR_W-3:0] idx;
  logic [31:0]       old_word, merged, load_word;
  logic [1:0]        lane_a;
  logic [2:0]        lane_mode;
  logic              misalign, mem_we;

  assign idx      = a_q[ADDR_W-1:2];
  assign old_word = mem_q[idx];
  // In IDLE the lane unit checks the live request; afterwards it works on latched operands.
  assign lane_a    = (state_q == StIdle) ? A[1:0] : a_q[1:0];
  assign lane_mode = (state_q == StIdle) ? mode : mode_q;

  dm_lane_unit u_lane (
    .old_word_i (old_word),
    .wd_i       (wd_q),
    .a_lo_i     (lane_a),
    .mode_i     (lane_mode),
    .merged_o   (merged),
    .load_o     (load_word),
    .misalign_o (misalign)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    mode_d  = mode_q;
    a_d     = a_q;
    wd_d    = wd_q;
    pc_d    = pc_q;
    data_d  = data_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          we_d   = we;
          mode_d = mode;
          a_d    = A;
          wd_d   = WD;
          pc_d   = PC;
          if (misalign || (mode > MODE_BS)) begin
            state_d = StDone;
            err_d   = 1'b1;
            data_d  = '0;
          end else begin
            state_d = StWait;
            cnt_d   = CntInit;
            err_d   = 1'b0;
          end
        end
      end
      StWait: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          mem_we  = we_q;
          data_d  = we_q ? 32'h0 : load_word;
          err_d   = 1'b0;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      mode_q  <= MODE_W;
      a_q     <= '0;
      wd_q    <= '0;
      pc_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      mode_q  <= mode_d;
      a_q     <= a_d;
      wd_q    <= wd_d;
      pc_q    <= pc_d;
      data_q  <= data_d;
      err_q   <= err_d;
      if (mem_we) mem_q[idx] <= merged;
    end
  end

  if (TRACE != 0) begin : g_trace
    always_ff @(posedge clk) begin
      if (!reset && mem_we) $display("@%h: *%h <= %h", pc_q, {a_q[31:2], 2'b00}, merged);
    end
  end

  assign busy     = (state_q != StIdle);
  assign ready    = (state_q == StDone);
  assign data     = data_q;
  assign addr_err = err_q;

endmodule

// File: tb/tb_dm_mc.sv
// Bench for dm_mc: directed scenarios plus random traffic on a LATENCY=2 and
// a LATENCY=1 instance, checked against a word-array reference model.
module tb_dm_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_s   [2];
  logic        we_s    [2];
  logic [2:0]  mode_s  [2];
  logic [31:0] pc_s    [2];
  logic [31:0] a_s     [2];
  logic [31:0] wd_s    [2];
  logic        busy_s  [2];
  logic        ready_s [2];
  logic [31:0] data_s  [2];
  logic        err_s   [2];

  int          n_checks = 0;
  int          n_pass   = 0;
  int          lat_of   [2] = '{2, 1};
  logic [31:0] ref_mem  [2][1024];

  always #5 clk = ~clk;

  dm_mc #(.ADDR_W(12), .LATENCY(2), .TRACE(1)) u_dut2 (
    .clk(clk), .reset(rst), .req(req_s[0]), .we(we_s[0]), .mode(mode_s[0]), .PC(pc_s[0]),
    .A(a_s[0]), .WD(wd_s[0]), .busy(busy_s[0]), .ready(ready_s[0]), .data(data_s[0]),
    .addr_err(err_s[0])
  );

  dm_mc #(.ADDR_W(12), .LATENCY(1), .TRACE(1)) u_dut1 (
    .clk(clk), .reset(rst), .req(req_s[1]), .we(we_s[1]), .mode(mode_s[1]), .PC(pc_s[1]),
    .A(a_s[1]), .WD(wd_s[1]), .busy(busy_s[1]), .ready(ready_s[1]), .data(data_s[1]),
    .addr_err(err_s[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic void clear_model();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 1024; i++) ref_mem[s][i] = '0;
  endfunction

  // Reference: memory as plain words, lanes handled with shifts and masks.
  function automatic void model(input int s, input logic w, input logic [2:0] m,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic err, output logic [31:0] d);
    int          idx  = int'(a[11:2]);
    int          sh   = 8 * int'(a[1:0]);
    int          size = (m == 0) ? 4 : (m <= 2) ? 2 : 1;
    logic [31:0] mask = (size == 4) ? 32'hFFFF_FFFF : (size == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
    logic [31:0] v;
    err = (m > 4) || (m == 0 && a[1:0] != 2'b00) || ((m == 1 || m == 2) && a[0]);
    d   = '0;
    if (err) return;
    if (w) begin
      ref_mem[s][idx] = (ref_mem[s][idx] & ~(mask << sh)) | ((wd & mask) << sh);
    end else begin
      v = (ref_mem[s][idx] >> sh) & mask;
      if ((m == 2 || m == 4) && v[8*size-1]) v = v | ~mask;
      d = v;
    end
  endfunction

  // Starts at #1 after an edge with the DUT idle; returns #1 after it is idle again.
  task automatic access(input int s, input logic w, input logic [2:0] m, input logic [31:0] a,
                        input logic [31:0] wd, input bit hold, output logic [31:0] got);
    logic        exp_err;
    logic [31:0] exp_d;
    int          n;
    model(s, w, m, a, wd, exp_err, exp_d);
    req_s[s] = 1'b1; we_s[s] = w; mode_s[s] = m; a_s[s] = a; wd_s[s] = wd;
    pc_s[s] = $urandom();
    @(posedge clk); #1;
    if (hold) begin
      we_s[s] = 1'b1; mode_s[s] = 3'd0; a_s[s] = a + 32'd4; wd_s[s] = 32'hDEAD_BEEF;
    end else begin
      req_s[s] = 1'b0;
    end
    check("busy_after_accept", 32'(busy_s[s]), 32'd1);
    n = 0;
    while (!ready_s[s] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    req_s[s] = 1'b0;
    check("ready_latency", n, exp_err ? 0 : lat_of[s]);
    check("addr_err", 32'(err_s[s]), 32'(exp_err));
    check("data", data_s[s], exp_d);
    got = data_s[s];
    @(posedge clk); #1;
    check("busy_after_done", 32'(busy_s[s]), 32'd0);
    check("ready_pulse_end", 32'(ready_s[s]), 32'd0);
    if (hold) begin
      @(posedge clk); #1;
      check("no_second_access", 32'(busy_s[s]), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] a;
    for (int s = 0; s < 2; s++) begin
      req_s[s] = 0; we_s[s] = 0; mode_s[s] = 0; pc_s[s] = 0; a_s[s] = 0; wd_s[s] = 0;
    end
    clear_model();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy_s[0]), 32'd0);
    check("rst_ready", 32'(ready_s[0]), 32'd0);
    check("rst_data", data_s[0], 32'd0);
    check("rst_err", 32'(err_s[0]), 32'd0);
    rst = 1'b0;

    access(0, 1, 3'd0, 32'h10, 32'h1234_5678, 0, got);
    access(0, 0, 3'd0, 32'h10, 32'h0, 0, got);
    check("lw_0x10", got, 32'h1234_5678);
    access(0, 1, 3'd3, 32'h11, 32'hFFFF_FFAB, 0, got);
    access(0, 0, 3'd0, 32'h10, 32'h0, 0, got);
    check("sb_merge", got, 32'h1234_AB78);
    access(0, 0, 3'd4, 32'h11, 32'h0, 0, got);
    check("lb", got, 32'hFFFF_FFAB);
    access(0, 0, 3'd3, 32'h11, 32'h0, 0, got);
    check("lbu", got, 32'h0000_00AB);
    access(0, 1, 3'd1, 32'h12, 32'h0000_8001, 0, got);
    access(0, 0, 3'd0, 32'h10, 32'h0, 0, got);
    check("sh_merge", got, 32'h8001_AB78);
    access(0, 0, 3'd2, 32'h12, 32'h0, 0, got);
    check("lh", got, 32'hFFFF_8001);
    access(0, 0, 3'd1, 32'h12, 32'h0, 0, got);
    check("lhu", got, 32'h0000_8001);

    access(0, 0, 3'd0, 32'h13, 32'h0, 0, got);
    access(0, 1, 3'd1, 32'h11, 32'hFFFF_FFFF, 0, got);
    access(0, 1, 3'd6, 32'h10, 32'hFFFF_FFFF, 0, got);
    access(0, 0, 3'd0, 32'h10, 32'h0, 0, got);
    check("err_no_write", got, 32'h8001_AB78);

    access(0, 1, 3'd0, 32'h30, 32'hCAFE_F00D, 1, got);
    access(0, 0, 3'd0, 32'h30, 32'h0, 0, got);
    check("hold_latched", got, 32'hCAFE_F00D);
    access(0, 0, 3'd0, 32'h34, 32'h0, 0, got);
    check("hold_no_requeue", got, 32'h0);

    // Reset while a store to 0x20 sits in WAIT.
    req_s[0] = 1'b1; we_s[0] = 1'b1; mode_s[0] = 3'd0; a_s[0] = 32'h20; wd_s[0] = 32'h5555_AAAA;
    @(posedge clk); #1;
    req_s[0] = 1'b0;
    check("wait_busy", 32'(busy_s[0]), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_in_wait_busy", 32'(busy_s[0]), 32'd0);
    check("rst_in_wait_ready", 32'(ready_s[0]), 32'd0);
    rst = 1'b0;
    clear_model();
    access(0, 0, 3'd0, 32'h20, 32'h0, 0, got);
    check("dropped_store", got, 32'h0);
    access(0, 0, 3'd0, 32'h10, 32'h0, 0, got);
    check("reset_clears_mem", got, 32'h0);

    access(1, 1, 3'd0, 32'h1004, 32'hA5A5_0101, 0, got);
    access(1, 0, 3'd0, 32'h4, 32'h0, 0, got);
    check("alias_lw", got, 32'hA5A5_0101);

    for (int i = 0; i < 300; i++) begin
      int s = (i % 5 == 4) ? 1 : 0;
      a = {$urandom_range(0, 3) == 0 ? 20'($urandom()) : 20'h0, 6'h0, 6'($urandom_range(0, 63))};
      access(s, 1'($urandom()), 3'($urandom_range(0, 7)), a, $urandom(), 0, got);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dm_mc.md
# dm_mc

Parametrised multi-cycle data memory for the MIPS datapath, successor to the single-cycle word-only DM. Supports byte, halfword and word stores/loads with sign/zero extension, detects misaligned accesses, and models a configurable access latency behind a req/ready handshake so the pipeline/multi-cycle controller can stall on memory. Sits in the MEM stage between the ALU address output and the register-file write-back mux; emits the standard store trace line.

## Interface
- ADDR_W, 12, byte-address bits used; depth = 2^(ADDR_W-2) 32-bit words; A[31:ADDR_W] ignored (aliasing wrap)
- LATENCY, 2, cycles from request acceptance to access commit; legal range 1..15
- TRACE, 1, 1 = $display on every committed store

- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- req  in  1  access request, sampled only when busy=0
- we  in  1  1 = store, 0 = load; sampled with req
- mode  in  3  0 word, 1 half unsigned, 2 half signed, 3 byte unsigned, 4 byte signed; 5-7 illegal
- PC  in  32  instruction address, trace only
- A  in  32  byte address
- WD  in  32  store data, low-aligned (sb uses WD[7:0], sh uses WD[15:0])
- busy  out  1  high whenever state != IDLE
- ready  out  1  one-cycle completion pulse
- data  out  32  extended load data; valid while ready=1, held until next acceptance
- addr_err  out  1  valid with ready; 1 = misaligned or illegal mode, no access performed

## Operation
- States IDLE, WAIT, DONE.
- IDLE, req=1: latch we, mode, A, WD, PC. If misaligned (word with A[1:0]!=0, half with A[0]=1) or mode>=5: go DONE, addr_err=1, data=0. Else go WAIT, cnt=LATENCY-1.
- WAIT: cnt!=0 -> cnt-1. cnt==0 -> commit access, go DONE.
- DONE: ready=1 for exactly one cycle; next edge -> IDLE. req while busy=1 (WAIT or DONE) is ignored, not queued.
- Store commit: read-modify-write of word A[ADDR_W-1:2]; byte lane A[1:0] <- WD[7:0]; half lane A[1] <- WD[15:0]; word <- WD. Trace "@%h: *%h <= %h" with PC, {A[31:2],2'b00}, merged word.
- Load commit: data <- selected lane, sign-extended (modes 2, 4) or zero-extended (1, 3); load of word returns word. Stores return data=0.
- Loads/stores use latched operands; input changes after acceptance have no effect.

## Timing
- Request sampled at edge E0; commit at edge E_LATENCY; ready high between E_LATENCY and E_LATENCY+1. Error path: ready high between E0 and E1.
- Throughput: one access per LATENCY+2 cycles.
- Store visible to a load accepted in or after the store's DONE cycle.
- Reset (any state, including WAIT): state IDLE, cnt 0, busy 0, ready 0, addr_err 0, data 0, all memory words 0; pending store dropped, no trace line. Reset wins over req in same cycle.
- cnt width 4 bits; no wrap possible within legal LATENCY.

## Structure
- Shared package dm_pkg: mode encodings (MODE_W, MODE_HU, MODE_HS, MODE_BU, MODE_BS), state encoding, LATENCY bounds.
- Sub-module dm_lane_unit (combinational): inputs old word, WD, A[1:0], mode; outputs merged store word, extended load word, misalign flag. FSM, counter, array and trace stay in dm_mc.

## Test plan
- LATENCY=2: sw A=0x10 WD=0x12345678 at E0 -> busy E0..E3, ready in cycle after E2, trace "*00000010 <= 12345678"; then lw 0x10 -> data=0x12345678.
- sb A=0x11 WD=0xFFFFFFAB over word 0x12345678 -> word 0x1234AB78; lb 0x11 -> 0xFFFFFFAB; lbu 0x11 -> 0x000000AB.
- sh A=0x12 WD=0x00008001 -> word 0x8001AB78; lh 0x12 -> 0xFFFF8001; lhu -> 0x00008001.
- lw A=0x13, sh A=0x11, mode=6 -> ready one cycle after E0, addr_err=1, data=0, memory unchanged, no trace.
- req held high through WAIT/DONE -> only one access; reset asserted in WAIT of sw 0x20 -> busy=0 next cycle, lw 0x20 returns 0, no trace.
- LATENCY=1 and ADDR_W=12: sw A=0x1004 aliases word 1; lw 0x4 returns stored value, ready one cycle after E1.
